// File: rtl/motor_step_gen_mc_pkg.sv
// Shared definitions for the multi-channel step/dir generator: channel phase
// encoding and default widths/timing constants.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIR_SETUP = 3'd1,
        ST_PRE       = 3'd2,
        ST_PULSE     = 3'd3,
        ST_POST      = 3'd4
    } chan_state_e;

    localparam int DEF_NCH   = 3;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_POS_W = 32;

    // A zero pulse length still produces one high cycle.
    localparam int MIN_PULSE_LEN = 1;

endpackage

// File: rtl/motor_step_gen_mc_if.sv
// Planner-side bundle of the step generator: strobes, timing, position load/snapshot
// and the pin/status outputs. master drives requests, slave is the generator.
interface motor_step_gen_mc_if #(
    parameter int NCH   = 3,
    parameter int CNT_W = 16,
    parameter int POS_W = 32
);
    logic [NCH-1:0]       enable;
    logic [NCH-1:0]       step_stb;
    logic [NCH-1:0]       step_dir;
    logic [CNT_W-1:0]     dir_setup_len;
    logic [CNT_W-1:0]     pre_len;
    logic [CNT_W-1:0]     pulse_len;
    logic [CNT_W-1:0]     post_len;
    logic [NCH-1:0]       set_x;
    logic [NCH*POS_W-1:0] x_val;
    logic                 hold;
    logic [NCH-1:0]       missed_clr;

    logic [NCH-1:0]       step;
    logic [NCH-1:0]       dir;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       missed;
    logic [NCH*POS_W-1:0] x;
    logic [NCH*POS_W-1:0] x_hold;

    modport master (
        output enable, step_stb, step_dir, dir_setup_len, pre_len, pulse_len, post_len,
        output set_x, x_val, hold, missed_clr,
        input  step, dir, busy, missed, x, x_hold
    );

    modport slave (
        input  enable, step_stb, step_dir, dir_setup_len, pre_len, pulse_len, post_len,
        input  set_x, x_val, hold, missed_clr,
        output step, dir, busy, missed, x, x_hold
    );
endinterface

// File: rtl/motor_step_gen_mc_chan.sv
// One step/dir axis: phase sequencer with per-step shadowed timing, signed
// position counter with load and snapshot, and a sticky missed-strobe flag.
module motor_step_chan
    import motor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int POS_W = DEF_POS_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    step_stb_i,
    input  logic                    step_dir_i,
    input  logic [CNT_W-1:0]        dir_setup_len_i,
    input  logic [CNT_W-1:0]        pre_len_i,
    input  logic [CNT_W-1:0]        pulse_len_i,
    input  logic [CNT_W-1:0]        post_len_i,
    input  logic                    set_x_i,
    input  logic signed [POS_W-1:0] x_val_i,
    input  logic                    hold_i,
    input  logic                    missed_clr_i,
    output logic                    step_o,
    output logic                    dir_o,
    output logic                    busy_o,
    output logic                    missed_o,
    output logic signed [POS_W-1:0] x_o,
    output logic signed [POS_W-1:0] x_hold_o
);

    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    // Counter value loaded on phase entry: the phase ends on the edge that sees zero.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] eff;
        eff = (len == '0) ? CNT_W'(MIN_PULSE_LEN) : len;
        return eff - CNT_ONE;
    endfunction

    chan_state_e             state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    step_q;
    logic                    dir_q;
    logic                    busy_q;
    logic                    missed_q, missed_d;
    logic signed [POS_W-1:0] x_q, x_d;
    logic signed [POS_W-1:0] x_hold_q, x_hold_d;
    logic [CNT_W-1:0]        pre_q;
    logic [CNT_W-1:0]        pulse_q;
    logic [CNT_W-1:0]        post_q;

    logic accept;
    logic miss;
    logic dir_chg;

    assign accept  = (state_q == ST_IDLE) && enable_i && step_stb_i;
    assign miss    = (state_q != ST_IDLE) && enable_i && step_stb_i;
    assign dir_chg = (step_dir_i != dir_q);

    always_comb begin
        x_d = x_q;
        if (set_x_i) begin
            x_d = x_val_i;
        end else if (accept) begin
            x_d = step_dir_i ? (x_q - POS_ONE) : (x_q + POS_ONE);
        end
        x_hold_d = hold_i ? x_q : x_hold_q;
        missed_d = miss ? 1'b1 : (missed_clr_i ? 1'b0 : missed_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dir_q  <= step_dir_i;
                        busy_q <= 1'b1;
                        // First phase decided from live inputs; shadows load on this same edge.
                        if (dir_chg && (dir_setup_len_i != '0)) begin
                            state_q <= ST_DIR_SETUP;
                            cnt_q   <= last_cnt(dir_setup_len_i);
                        end else if (pre_len_i != '0) begin
                            state_q <= ST_PRE;
                            cnt_q   <= last_cnt(pre_len_i);
                        end else begin
                            state_q <= ST_PULSE;
                            cnt_q   <= last_cnt(pulse_len_i);
                            step_q  <= 1'b1;
                        end
                    end
                end
                ST_DIR_SETUP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (pre_q != '0) begin
                        state_q <= ST_PRE;
                        cnt_q   <= last_cnt(pre_q);
                    end else begin
                        state_q <= ST_PULSE;
                        cnt_q   <= last_cnt(pulse_q);
                        step_q  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        state_q <= ST_PULSE;
                        cnt_q   <= last_cnt(pulse_q);
                        step_q  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        step_q <= 1'b0;
                        if (post_q != '0) begin
                            state_q <= ST_POST;
                            cnt_q   <= last_cnt(post_q);
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_POST: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Timing shadows are pure data: only meaningful while busy, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pre_q   <= pre_len_i;
            pulse_q <= pulse_len_i;
            post_q  <= post_len_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            x_hold_q <= '0;
            missed_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            x_hold_q <= x_hold_d;
            missed_q <= missed_d;
        end
    end

    assign step_o   = step_q;
    assign dir_o    = dir_q;
    assign busy_o   = busy_q;
    assign missed_o = missed_q;
    assign x_o      = x_q;
    assign x_hold_o = x_hold_q;

endmodule

// File: rtl/motor_step_gen_mc.sv
// Multi-axis step/dir generator: NCH independent channels sharing only the
// timing inputs; this level just slices the bundle vectors per channel.
module motor_step_gen_mc
    import motor_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int POS_W = DEF_POS_W
) (
    input  logic                clk,
    input  logic                reset_n,
    motor_step_gen_mc_if.slave  bus
);

    logic [NCH-1:0]       step_w;
    logic [NCH-1:0]       dir_w;
    logic [NCH-1:0]       busy_w;
    logic [NCH-1:0]       missed_w;
    logic [NCH*POS_W-1:0] x_w;
    logic [NCH*POS_W-1:0] x_hold_w;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        motor_step_chan #(
            .CNT_W (CNT_W),
            .POS_W (POS_W)
        ) u_chan (
            .clk             (clk),
            .reset_n         (reset_n),
            .enable_i        (bus.enable[i]),
            .step_stb_i      (bus.step_stb[i]),
            .step_dir_i      (bus.step_dir[i]),
            .dir_setup_len_i (bus.dir_setup_len),
            .pre_len_i       (bus.pre_len),
            .pulse_len_i     (bus.pulse_len),
            .post_len_i      (bus.post_len),
            .set_x_i         (bus.set_x[i]),
            .x_val_i         (bus.x_val[i*POS_W +: POS_W]),
            .hold_i          (bus.hold),
            .missed_clr_i    (bus.missed_clr[i]),
            .step_o          (step_w[i]),
            .dir_o           (dir_w[i]),
            .busy_o          (busy_w[i]),
            .missed_o        (missed_w[i]),
            .x_o             (x_w[i*POS_W +: POS_W]),
            .x_hold_o        (x_hold_w[i*POS_W +: POS_W])
        );
    end

    assign bus.step   = step_w;
    assign bus.dir    = dir_w;
    assign bus.busy   = busy_w;
    assign bus.missed = missed_w;
    assign bus.x      = x_w;
    assign bus.x_hold = x_hold_w;

endmodule

// File: tb/tb_motor_step_gen_mc.sv
// Directed bench for motor_step_gen_mc: stimulus queues hand-computed expectations
// tagged with a cycle number; a monitor compares them at the falling edge.
module tb_motor_step_gen_mc;

    localparam int NCH   = 3;
    localparam int CNT_W = 16;
    localparam int POS_W = 32;

    localparam int S_STEP = 0, S_BUSY = 1, S_DIR = 2, S_MISS = 3, S_X = 4, S_XH = 5;

    typedef struct {
        int          cyc;
        int          sel;
        int          ch;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;
    int   T, C, S, U, P, H, W;
    logic [31:0] act;
    exp_t sbq[$];

    motor_step_gen_mc_if #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

    motor_step_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel, input int ch);
        case (sel)
            S_STEP:  return {31'b0, bus.step[ch]};
            S_BUSY:  return {31'b0, bus.busy[ch]};
            S_DIR:   return {31'b0, bus.dir[ch]};
            S_MISS:  return {31'b0, bus.missed[ch]};
            S_X:     return bus.x[ch*POS_W +: POS_W];
            default: return bus.x_hold[ch*POS_W +: POS_W];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return at 1 time unit after edge e-1, so inputs set next are sampled at edge e.
    task automatic go(input int e);
        while (cyc < e - 1) tick();
    endtask

    task automatic ex(input int c, input int sel, input int ch, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.sel = sel; e.ch = ch; e.val = v; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic wave(input int sel, input int ch, input int c0, input int c1,
                        input int on0, input int on1, input string nm);
        for (int c = c0; c <= c1; c++)
            ex(c, sel, ch, (c >= on0 && c <= on1) ? 32'd1 : 32'd0, nm);
    endtask

    task automatic all_zero(input int c, input string nm);
        for (int ch = 0; ch < NCH; ch++)
            for (int s = S_STEP; s <= S_XH; s++)
                ex(c, s, ch, 32'd0, nm);
    endtask

    task automatic strobe(input int e, input logic [NCH-1:0] m, input logic [NCH-1:0] d);
        go(e);
        bus.step_stb = m;
        bus.step_dir = d;
        tick();
        bus.step_stb = '0;
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.enable        = '1;
        bus.step_stb      = '0;
        bus.step_dir      = '0;
        bus.dir_setup_len = '0;
        bus.pre_len       = 16'd2;
        bus.pulse_len     = 16'd3;
        bus.post_len      = 16'd4;
        bus.set_x         = '0;
        bus.x_val         = '0;
        bus.hold          = 1'b0;
        bus.missed_clr    = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    for (int i = sbq.size() - 1; i >= 0; i--) begin
                        if (sbq[i].cyc <= cyc) begin
                            act = actual(sbq[i].sel, sbq[i].ch);
                            nvec++;
                            if (sbq[i].cyc < cyc || act !== sbq[i].val) begin
                                nbad++;
                                $display("FAIL %s ch%0d cyc %0d: got %h, expected %h (due cyc %0d)",
                                         sbq[i].nm, sbq[i].ch, cyc, act, sbq[i].val, sbq[i].cyc);
                            end
                            sbq.delete(i);
                        end
                    end
                end
            end
            begin : stimulus
                tick(); tick();
                all_zero(cyc, "reset_state");
                tick();
                reset_n = 1'b1;
                tick();

                // Basic step ch0: pre 2, pulse 3, post 4
                T = cyc + 3;
                wave(S_STEP, 0, T - 1, T + 9, T + 2, T + 4, "t1_step");
                wave(S_BUSY, 0, T - 1, T + 9, T, T + 8, "t1_busy");
                ex(T - 1, S_X, 0, 32'd0, "t1_x_before");
                ex(T, S_X, 0, 32'd1, "t1_x");
                ex(T + 1, S_DIR, 0, 32'd0, "t1_dir");
                ex(T + 3, S_BUSY, 1, 32'd0, "t1_ch1_quiet");
                strobe(T, 3'b001, 3'b000);

                // Direction flip with setup 5, then same-direction repeat
                bus.dir_setup_len = 16'd5;
                T = T + 12;
                ex(T - 1, S_DIR, 0, 32'd0, "t2_dir_old");
                ex(T, S_DIR, 0, 32'd1, "t2_dir_new");
                wave(S_STEP, 0, T - 1, T + 14, T + 7, T + 9, "t2_step_setup");
                wave(S_BUSY, 0, T + 12, T + 14, T, T + 13, "t2_busy_end");
                ex(T, S_X, 0, 32'd0, "t2_x");
                strobe(T, 3'b001, 3'b001);
                T = T + 15;
                wave(S_STEP, 0, T, T + 9, T + 2, T + 4, "t2_step_nosetup");
                wave(S_BUSY, 0, T + 7, T + 9, T, T + 8, "t2_busy_nosetup");
                ex(T, S_X, 0, 32'hFFFF_FFFF, "t2_x_neg");
                ex(T + 5, S_DIR, 0, 32'd1, "t2_dir_hold");
                strobe(T, 3'b001, 3'b001);

                // Strobe while busy sets sticky missed; clear; clear racing a new miss
                T = T + 10;
                wave(S_STEP, 0, T, T + 9, T + 2, T + 4, "t3_step");
                ex(T, S_X, 0, 32'hFFFF_FFFE, "t3_x");
                ex(T + 6, S_X, 0, 32'hFFFF_FFFE, "t3_x_nomiss");
                ex(T + 3, S_MISS, 0, 32'd0, "t3_miss_pre");
                ex(T + 4, S_MISS, 0, 32'd1, "t3_miss_set");
                ex(T + 12, S_MISS, 0, 32'd1, "t3_miss_sticky");
                strobe(T, 3'b001, 3'b001);
                strobe(T + 4, 3'b001, 3'b001);
                C = T + 13;
                ex(C, S_MISS, 0, 32'd0, "t3_miss_clr");
                go(C);
                bus.missed_clr = 3'b001;
                tick();
                bus.missed_clr = '0;
                T = C + 2;
                ex(T, S_X, 0, 32'hFFFF_FFFD, "t3_x2");
                ex(T + 1, S_X, 0, 32'hFFFF_FFFD, "t3_x2_nomiss");
                ex(T + 1, S_MISS, 0, 32'd1, "t3_set_beats_clr");
                ex(T + 2, S_MISS, 0, 32'd1, "t3_set_beats_clr2");
                strobe(T, 3'b001, 3'b001);
                go(T + 1);
                bus.step_stb   = 3'b001;
                bus.missed_clr = 3'b001;
                tick();
                bus.step_stb   = '0;
                bus.missed_clr = '0;
                C = T + 10;
                ex(C, S_MISS, 0, 32'd0, "t3_miss_clr2");
                go(C);
                bus.missed_clr = 3'b001;
                tick();
                bus.missed_clr = '0;

                // Position wrap and set_x overriding a same-cycle accept
                bus.dir_setup_len = '0;
                S = C + 2;
                ex(S, S_X, 0, 32'h7FFF_FFFF, "t4_set_x");
                go(S);
                bus.set_x = 3'b001;
                bus.x_val[0 +: POS_W] = 32'h7FFF_FFFF;
                tick();
                bus.set_x = '0;
                T = S + 2;
                ex(T, S_X, 0, 32'h8000_0000, "t4_wrap");
                ex(T, S_DIR, 0, 32'd0, "t4_dir");
                wave(S_STEP, 0, T + 1, T + 5, T + 2, T + 4, "t4_step");
                strobe(T, 3'b001, 3'b000);
                U = T + 10;
                ex(U, S_X, 0, 32'h1234_5678, "t4_set_wins");
                ex(U + 1, S_X, 0, 32'h1234_5678, "t4_set_wins2");
                wave(S_STEP, 0, U, U + 6, U + 2, U + 4, "t4_step_with_set");
                go(U);
                bus.set_x = 3'b001;
                bus.x_val[0 +: POS_W] = 32'h1234_5678;
                bus.step_stb = 3'b001;
                bus.step_dir = 3'b000;
                tick();
                bus.set_x    = '0;
                bus.step_stb = '0;

                // hold snapshots pre-update values; reset mid-pulse clears everything
                P = U + 10;
                ex(P, S_X, 1, 32'h0000_0100, "t5_set_x1");
                go(P);
                bus.set_x = 3'b010;
                bus.x_val[POS_W +: POS_W] = 32'h0000_0100;
                tick();
                bus.set_x = '0;
                H = P + 2;
                ex(H, S_XH, 1, 32'h0000_0100, "t5_hold_old_x");
                ex(H, S_X, 1, 32'h0000_0101, "t5_x1_step");
                ex(H, S_XH, 0, 32'h1234_5678, "t5_hold_ch0");
                ex(H, S_XH, 2, 32'd0, "t5_hold_ch2");
                ex(H + 1, S_STEP, 1, 32'd0, "t5_pre");
                ex(H + 2, S_STEP, 1, 32'd1, "t5_pulse");
                go(H);
                bus.step_stb = 3'b010;
                bus.step_dir = 3'b000;
                bus.hold     = 1'b1;
                tick();
                bus.step_stb = '0;
                bus.hold     = 1'b0;
                all_zero(H + 3, "t5_async_reset");
                go(H + 4);
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                tick();

                // Three channels at once, shadowed timing, enable handling, min pulse
                bus.dir_setup_len = 16'd3;
                bus.pre_len       = 16'd1;
                bus.pulse_len     = 16'd2;
                bus.post_len      = 16'd0;
                bus.enable        = 3'b111;
                W = cyc + 3;
                wave(S_STEP, 0, W - 1, W + 7, W + 4, W + 5, "t6_step0");
                wave(S_BUSY, 0, W - 1, W + 7, W, W + 5, "t6_busy0");
                ex(W, S_DIR, 0, 32'd1, "t6_dir0");
                ex(W, S_X, 0, 32'hFFFF_FFFF, "t6_x0");
                for (int ch = 1; ch < NCH; ch++) begin
                    wave(S_STEP, ch, W - 1, W + 4, W + 1, W + 2, "t6_step");
                    wave(S_BUSY, ch, W - 1, W + 4, W, W + 2, "t6_busy");
                    ex(W, S_X, ch, 32'd1, "t6_x");
                end
                strobe(W, 3'b111, 3'b001);
                bus.dir_setup_len = 16'd11;
                bus.pre_len       = 16'd7;
                bus.pulse_len     = 16'd9;
                bus.post_len      = 16'd5;
                bus.enable        = 3'b110;
                go(W + 7);
                bus.dir_setup_len = '0;
                bus.pre_len       = '0;
                bus.pulse_len     = '0;
                bus.post_len      = '0;
                bus.enable        = 3'b011;
                wave(S_STEP, 1, W + 7, W + 9, W + 8, W + 8, "t6_min_step");
                wave(S_BUSY, 1, W + 7, W + 9, W + 8, W + 8, "t6_min_busy");
                ex(W + 8, S_X, 1, 32'd2, "t6_min_x");
                ex(W + 8, S_BUSY, 2, 32'd0, "t6_disabled_busy");
                ex(W + 9, S_MISS, 2, 32'd0, "t6_disabled_nomiss");
                ex(W + 9, S_X, 2, 32'd1, "t6_disabled_x");
                ex(W + 9, S_MISS, 1, 32'd1, "t6_miss_at_t1");
                ex(W + 9, S_X, 1, 32'd2, "t6_x_at_t1");
                ex(W + 10, S_X, 1, 32'd3, "t6_accept_t2");
                wave(S_STEP, 1, W + 10, W + 11, W + 10, W + 10, "t6_step_t2");
                wave(S_BUSY, 1, W + 10, W + 11, W + 10, W + 10, "t6_busy_t2");
                strobe(W + 8, 3'b110, 3'b000);
                strobe(W + 9, 3'b010, 3'b000);
                strobe(W + 10, 3'b010, 3'b000);
                go(W + 14);
                @(negedge clk);
                #1;
            end
        join_any

        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
            nbad += sbq.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
